// File: rtl/ofdm_tx_l1_clipper.sv
// L1-magnitude peak limiter for the OFDM TX path: samples whose |Re|+|Im| exceeds
// Threshold are scaled by floor(Threshold*2^15/mag) (Q0.15), preserving phase.
module ofdm_tx_l1_clipper (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic signed [15:0] InRe,
    input  logic signed [15:0] InIm,
    input  logic        [16:0] Threshold,
    output logic               OutValid,
    output logic signed [15:0] OutRe,
    output logic signed [15:0] OutIm,
    output logic               ClipFlag,
    output logic        [15:0] ClipCount
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAG   = 3'd1,
        DIV   = 3'd2,
        SCALE = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t             state_q;
    logic signed [15:0] re_q;
    logic signed [15:0] im_q;
    logic        [16:0] th_q;
    logic        [16:0] abs_re_q;
    logic        [16:0] abs_im_q;
    logic        [17:0] mag_q;
    logic        [18:0] rem_q;
    logic        [14:0] quo_q;
    logic        [3:0]  cnt_q;

    logic               in_ready_q;
    logic               out_valid_q;
    logic signed [15:0] out_re_q;
    logic signed [15:0] out_im_q;
    logic               clip_flag_q;
    logic        [15:0] clip_count_q;

    logic        [16:0] abs_re_d;
    logic        [16:0] abs_im_d;
    logic        [17:0] mag_d;
    logic        [18:0] rem_sh_d;
    logic               quo_bit_d;
    logic        [18:0] rem_d;

    // 17-bit magnitude so that -32768 maps to +32768 without overflow
    function automatic logic [16:0] abs17(input logic signed [15:0] v);
        logic signed [16:0] ext;
        ext = {v[15], v};
        return v[15] ? 17'(-ext) : 17'(ext);
    endfunction

    // Truncating scale keeps |out| <= |in|*ratio/2^15, so the L1 result never exceeds Threshold
    function automatic logic signed [15:0] scale16(input logic        sign_neg,
                                                   input logic [16:0] a,
                                                   input logic [14:0] r);
        logic [31:0] prod;
        logic [15:0] m;
        prod = {15'd0, a} * {17'd0, r};
        m    = prod[30:15];
        return sign_neg ? $signed(-m) : $signed(m);
    endfunction

    always_comb begin
        abs_re_d  = abs17(re_q);
        abs_im_d  = abs17(im_q);
        mag_d     = {1'b0, abs_re_d} + {1'b0, abs_im_d};
        rem_sh_d  = {rem_q[17:0], 1'b0};
        quo_bit_d = (rem_sh_d >= {1'b0, mag_q});
        rem_d     = quo_bit_d ? (rem_sh_d - {1'b0, mag_q}) : rem_sh_d;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            re_q         <= '0;
            im_q         <= '0;
            th_q         <= '0;
            abs_re_q     <= '0;
            abs_im_q     <= '0;
            mag_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            clip_flag_q  <= 1'b0;
            clip_count_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (InValid && in_ready_q) begin
                        re_q       <= InRe;
                        im_q       <= InIm;
                        th_q       <= Threshold;
                        in_ready_q <= 1'b0;
                        state_q    <= MAG;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                MAG: begin
                    abs_re_q <= abs_re_d;
                    abs_im_q <= abs_im_d;
                    mag_q    <= mag_d;
                    rem_q    <= {2'b00, th_q};
                    quo_q    <= '0;
                    cnt_q    <= '0;
                    if ((th_q == 17'd0) || (mag_d <= {1'b0, th_q})) begin
                        out_re_q    <= re_q;
                        out_im_q    <= im_q;
                        clip_flag_q <= 1'b0;
                        state_q     <= OUT;
                    end else begin
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    // Remainder starts at Threshold < mag, so 15 steps yield the full Q0.15 ratio
                    rem_q <= rem_d;
                    quo_q <= {quo_q[13:0], quo_bit_d};
                    if (cnt_q == 4'd14) begin
                        state_q <= SCALE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                SCALE: begin
                    out_re_q    <= scale16(re_q[15], abs_re_q, quo_q);
                    out_im_q    <= scale16(im_q[15], abs_im_q, quo_q);
                    clip_flag_q <= 1'b1;
                    if (clip_count_q != 16'hFFFF) begin
                        clip_count_q <= clip_count_q + 16'd1;
                    end
                    state_q <= OUT;
                end
                OUT: begin
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign InReady   = in_ready_q;
    assign OutValid  = out_valid_q;
    assign OutRe     = out_re_q;
    assign OutIm     = out_im_q;
    assign ClipFlag  = clip_flag_q;
    assign ClipCount = clip_count_q;

endmodule

// File: doc/ofdm_tx_l1_clipper.md
# ofdm_tx_l1_clipper

Transmit-side peak limiter for the OFDM TX chain, placed between the IFFT/cyclic-prefix output and the DAC interface. It measures each complex sample's amplitude with the same |Re|+|Im| (L1) approximation the receiver uses for magnitude. Any sample whose L1 magnitude exceeds a programmable threshold is scaled down uniformly by Threshold/magnitude, preserving phase. Scaling uses a sequential restoring divider, and input backpressure is handled with a valid/ready handshake.

## Interface
- No parameters; widths are fixed. Samples are 16-bit two's complement, threshold is 17-bit unsigned, ratio is Q0.15.
- Clk  in  1  system clock; single clock domain.
- Rst_n  in  1  reset; **synchronous, active-low**.
- InValid  in  1  input sample valid.
- InReady  out  1  block can accept a sample this cycle.
- InRe  in  16  real part, two's complement.
- InIm  in  16  imaginary part, two's complement.
- Threshold  in  17  unsigned L1 limit; sampled on accept; 0 = bypass.
- OutValid  out  1  one-cycle strobe; output has no backpressure.
- OutRe  out  16  limited real part.
- OutIm  out  16  limited imaginary part.
- ClipFlag  out  1  qualified by OutValid; 1 = the sample was scaled.
- ClipCount  out  16  number of clipped samples since reset; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, MAG, DIV, SCALE, OUT. The reset state is IDLE.
- **IDLE**
  - InReady=1.
  - On InValid&InReady, register InRe, InIm and Threshold, then go to MAG.
- **MAG**
  - absRe/absIm are 17 bits wide, so -32768 maps to 32768.
  - mag = absRe+absIm, 18 bits.
  - If Threshold==0 or mag<=Threshold: output the original sample, ClipFlag=0, go to OUT.
  - Otherwise: go to DIV.
- **DIV**
  - Restoring divide: ratio = floor(Threshold·2^15 / mag).
  - One quotient bit per cycle, MSB first; 15 cycles total.
  - ratio < 2^15 is guaranteed because Threshold < mag.
- **SCALE**
  - OutRe = sign(Re)·floor(absRe·ratio / 2^15); OutIm is computed the same way.
  - Rounding is toward zero, so |OutRe|+|OutIm| <= Threshold always holds.
  - Results always fit in 16 bits.
  - ClipFlag=1. ClipCount increments unless it is already 0xFFFF. Go to OUT.
- **OUT**
  - OutValid=1 for exactly one cycle, then return to IDLE.
- Output and flag behaviour:
  - OutRe, OutIm and ClipFlag hold their values until the next OUT.
  - They are registered outputs driven only from the FSM.
- InReady is 0 in every state except IDLE. A sample presented while InReady=0 is not consumed; the source must hold it.
- A reset asserted mid-operation on any edge clears everything:
  - FSM returns to IDLE.
  - The in-flight sample is discarded; no OutValid is produced for it.
  - ClipCount is cleared.

## Timing
- Reset values: InReady=0 during reset and 1 from the first cycle after Rst_n deasserts. OutValid=0, OutRe=0, OutIm=0, ClipFlag=0, ClipCount=0.
- Define T as the accept edge.
  - **Unclipped:** OutValid is high in the cycle following edge T+2, i.e. a latency of 2 cycles. InReady returns to 1 one cycle later, giving a maximum throughput of 1 sample per 3 cycles.
  - **Clipped:** 1 MAG + 15 DIV + 1 SCALE cycles, so OutValid is high after edge T+18. The next accept is possible 1 cycle after OutValid.
- A Threshold change while a sample is in flight has no effect on that sample.
- ClipCount updates on the same edge that enters OUT, so it is coherent with OutValid.

## Test plan
- Pass-through: Threshold=1000, sample (300,400).
  - Expect OutValid 2 cycles after accept with (300,400), ClipFlag=0, ClipCount=0.
- Clip: Threshold=1000, sample (3000,-1000).
  - mag=4000, ratio=8192.
  - Expect output (750,-250), ClipFlag=1, latency 18, ClipCount=1.
- Extreme negative: Threshold=16384, sample (-32768,-32768).
  - mag=65536, ratio=8192.
  - Expect (-8192,-8192), ClipFlag=1.
- Bypass and boundary: Threshold=0 with sample (32767,-32768), and Threshold=700 with sample (300,400).
  - Expect both unchanged, ClipFlag=0 (mag equal to Threshold does not clip).
- Backpressure: hold InValid=1 with changing data that only updates on accept, across three back-to-back clipped samples.
  - Expect exactly three outputs, in order, none dropped or duplicated.
  - Expect InReady low for 18 cycles after each accept.
- Reset mid-DIV: assert Rst_n=0 for 1 cycle 5 cycles after a clipping accept.
  - Expect no OutValid, all outputs 0, ClipCount=0.
  - Expect InReady=1 on the cycle after reset is released.
